// File: rtl/paraleloserie_tx.sv
// Parallel-to-serial lane transmitter: COM preamble after reset, then MSB-first bytes with idle fill.
// Optional build macro PARALELOSERIE_IDLE_COM_EN sends K_COM instead of K_IDL as the idle filler.
module paraleloserie_tx #(
  parameter int unsigned COM_COUNT = 4,
  parameter logic [7:0]  K_COM     = 8'hBC,
  parameter logic [7:0]  K_IDL     = 8'h7C
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       valid_in,
  output logic       out,
  output logic       ready,
  output logic       tx_active
);

  typedef enum logic {ST_SYNC = 1'b0, ST_ACTIVE = 1'b1} state_t;

  localparam logic [3:0] LAST_COM = 4'(COM_COUNT - 1);

  state_t     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [3:0] synccnt_q, synccnt_d;
  logic [7:0] shift_q, shift_d;
  logic       out_q, out_d;
  logic       tx_active_q, tx_active_d;
  logic       load_s;
  logic       last_com_s;
  logic       ready_s;
  logic [7:0] sel_s;
  logic [7:0] filler_s;

  assign load_s     = (bitcnt_q == 3'd0);
  assign last_com_s = (synccnt_q == LAST_COM);

`ifdef PARALELOSERIE_IDLE_COM_EN
  assign filler_s = K_COM;
`else
  assign filler_s = K_IDL;
`endif

  always_ff @(posedge clk32f) begin
    if (!reset) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: begin
        if (load_s && last_com_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_ACTIVE: state_d = ST_ACTIVE;
      default:   state_d = ST_SYNC;
    endcase
  end

  // Byte selection and handshake are decoded from registered state only.
  always_comb begin
    ready_s = 1'b0;
    sel_s   = K_COM;
    case (state_q)
      ST_SYNC: begin
        ready_s = 1'b0;
        sel_s   = K_COM;
      end
      ST_ACTIVE: begin
        ready_s = load_s;
        if (valid_in) begin
          sel_s = in;
        end else begin
          sel_s = filler_s;
        end
      end
      default: begin
        ready_s = 1'b0;
        sel_s   = K_COM;
      end
    endcase
  end

  always_comb begin
    bitcnt_d    = bitcnt_q + 3'd1;
    synccnt_d   = synccnt_q;
    tx_active_d = tx_active_q;
    if (load_s) begin
      out_d   = sel_s[7];
      shift_d = {sel_s[6:0], 1'b0};
      if (state_q == ST_SYNC) begin
        synccnt_d = synccnt_q + 4'd1;
        if (last_com_s) begin
          tx_active_d = 1'b1;
        end else begin
          tx_active_d = tx_active_q;
        end
      end else begin
        synccnt_d = synccnt_q;
      end
    end else begin
      out_d   = shift_q[7];
      shift_d = {shift_q[6:0], 1'b0};
    end
  end

  // A reset edge discards any partial byte; the first edge after release is always a load edge.
  always_ff @(posedge clk32f) begin
    if (!reset) begin
      bitcnt_q    <= 3'd0;
      synccnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      out_q       <= 1'b0;
      tx_active_q <= 1'b0;
    end else begin
      bitcnt_q    <= bitcnt_d;
      synccnt_q   <= synccnt_d;
      shift_q     <= shift_d;
      out_q       <= out_d;
      tx_active_q <= tx_active_d;
    end
  end

  assign out       = out_q;
  assign ready     = ready_s;
  assign tx_active = tx_active_q;

endmodule

// File: tb/tb_paraleloserie_tx.sv
// Scoreboard bench for paraleloserie_tx: a byte-stream reference model queues the expected
// out/ready/tx_active after every edge and a monitor compares them one edge at a time.
module tb_paraleloserie_tx;

  localparam int         CC    = 4;
  localparam logic [7:0] KCOM  = 8'hBC;
`ifdef PARALELOSERIE_IDLE_COM_EN
  localparam logic [7:0] FILL  = 8'hBC;
`else
  localparam logic [7:0] FILL  = 8'h7C;
`endif

  typedef struct packed {
    logic o;
    logic r;
    logic a;
  } exp_t;

  logic       clk32f = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] in     = 8'h00;
  logic       valid_in = 1'b0;
  logic       out;
  logic       ready;
  logic       tx_active;

  exp_t       expq[$];
  int         vectors = 0;
  int         errors  = 0;
  int         n       = 0;
  logic [7:0] cur     = 8'h00;

  paraleloserie_tx dut (
    .clk32f   (clk32f),
    .reset    (reset),
    .in       (in),
    .valid_in (valid_in),
    .out      (out),
    .ready    (ready),
    .tx_active(tx_active)
  );

  always #5 clk32f = ~clk32f;

  // Model: byte k of the stream starts at edge 8k after release; the first CC bytes are COM,
  // later bytes are the offered byte if valid at their first edge, else the filler.
  task automatic step(input logic rst_v, input logic vld, input logic [7:0] d);
    exp_t e;
    int   bi;
    @(negedge clk32f);
    reset    = rst_v;
    valid_in = vld;
    in       = d;
    if (!rst_v) begin
      e = '{o: 1'b0, r: 1'b0, a: 1'b0};
      n = 0;
    end else begin
      if (n % 8 == 0) begin
        if (n < 8 * CC) cur = KCOM;
        else            cur = vld ? d : FILL;
      end
      bi  = 7 - (n % 8);
      e.o = cur[bi];
      e.r = (n >= 8 * CC - 1) && (n % 8 == 7);
      e.a = (n >= 8 * (CC - 1));
      n++;
    end
    expq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk32f);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        vectors++;
        if (out !== e.o || ready !== e.r || tx_active !== e.a) begin
          errors++;
          $display("FAIL edge_check t=%0t: got out=%b ready=%b tx_active=%b, expected out=%b ready=%b tx_active=%b",
                   $time, out, ready, tx_active, e.o, e.r, e.a);
        end
      end
    end
  end

  initial begin : driver
    logic       v;
    logic [7:0] d;
    // Reset held with busy inputs
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF);
    // Preamble, A5, idle, FF then 00 back to back, stray valid at edge 51
    for (int k = 0; k < 72; k++) begin
      v = 1'b0;
      d = 8'($urandom);
      if (k == 32) begin v = 1'b1; d = 8'hA5; end
      if (k == 48) begin v = 1'b1; d = 8'hFF; end
      if (k == 51) begin v = 1'b1; end
      if (k == 56) begin v = 1'b1; d = 8'h00; end
      step(1'b1, v, d);
    end
    // Reset mid-byte of A5 at edge 35, then full preamble again
    step(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 35; k++) begin
      if (k == 32) step(1'b1, 1'b1, 8'hA5);
      else         step(1'b1, 1'b0, 8'($urandom));
    end
    step(1'b0, 1'b1, 8'hA5);
    for (int k = 0; k < 48; k++) step(1'b1, 1'b0, 8'($urandom));
    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) step(1'b0, 1'($urandom), 8'($urandom));
      else step(1'b1, ($urandom_range(0, 3) != 0), 8'($urandom));
    end
    @(negedge clk32f);
    @(negedge clk32f);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
